// File: rtl/tex_block_fill_ctrl.sv
// tex_block_fill_ctrl: fetches one 32-word SDRAM burst holding a 4x4 RGBA8888 block
// and writes its 16 texels to the texel cache as RGBA5652.
module tex_block_fill_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fill_req_i,
  input  logic [23:0] fill_addr_i,
  output logic        fill_busy_o,
  output logic        fill_done_o,
  output logic        mem_req_o,
  output logic [23:0] mem_addr_o,
  output logic [5:0]  mem_burst_len_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        cache_we_o,
  output logic [3:0]  cache_widx_o,
  output logic [17:0] cache_wdata_o
);
  typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DONE} state_t;
  state_t       state_q, state_d;
  logic [23:0]  addr_q, addr_d;
  logic [4:0]   word_q, word_d;
  logic [3:0]   tex_q, tex_d;
  logic [511:0] buf_q;
  logic [31:0]  texel;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      tex_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      tex_q   <= tex_d;
    end
  // The block buffer is fully rewritten by every fill, so it carries no reset.
  always_ff @(posedge clk)
    if (state_q == RECV && mem_rvalid_i) buf_q[{word_q, 4'd0} +: 16] <= mem_rdata_i;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    tex_d   = tex_q;
    case (state_q)
      IDLE: if (fill_req_i) begin
        state_d = REQ;
        addr_d  = fill_addr_i;
      end
      REQ:  if (mem_ack_i) state_d = RECV;
      RECV: if (mem_rvalid_i) begin
        word_d  = word_q + 5'd1;
        state_d = word_q == 5'd31 ? WRITE : RECV;
      end
      WRITE: begin
        tex_d   = tex_q + 4'd1;
        state_d = tex_q == 4'd15 ? DONE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign texel           = buf_q[{tex_q, 5'd0} +: 32];
  assign fill_busy_o     = state_q != IDLE;
  assign fill_done_o     = state_q == DONE;
  assign mem_req_o       = state_q == REQ;
  assign mem_addr_o      = mem_req_o ? addr_q : '0;
  assign mem_burst_len_o = 6'd32;
  assign cache_we_o      = state_q == WRITE;
  assign cache_widx_o    = cache_we_o ? tex_q : '0;
  assign cache_wdata_o   = cache_we_o ? {texel[7:3], texel[15:10], texel[23:19], texel[31:30]} : '0;
endmodule

// File: doc/tex_block_fill_ctrl.md
TEX_BLOCK_FILL_CTRL -- requirements
Module: tex_block_fill_ctrl

Interface
REQ-001 The block SHALL have no parameters; burst length is fixed at 32 words of 16 bits, and SDRAM word addresses are 24 bits wide.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rst_n input 1 (asynchronous, active-low).
REQ-003 fill_req  input  1  requests a fill of one 4x4 RGBA8888 block.
REQ-004 fill_addr  input  24  SDRAM word address of texel 0, low word.
REQ-005 fill_busy  output  1  fill in progress.
REQ-006 fill_done  output  1  one-cycle pulse when the last cache write has completed.
REQ-007 mem_req  output  1  burst read request to the SDRAM arbiter.
REQ-008 mem_addr  output  24  burst start address.
REQ-009 mem_burst_len  output  6  constant 32.
REQ-010 mem_ack  input  1  arbiter accepted the request.
REQ-011 mem_rdata  input  16  returned read word.
REQ-012 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-013 cache_we  output  1  texel cache write strobe.
REQ-014 cache_widx  output  4  texel index in the block, row-major (y*4+x).
REQ-015 cache_wdata  output  18  texel in RGBA5652 format: {R5,G6,B5,A2}.

Function
REQ-016 The block SHALL implement the states IDLE, REQ, RECV, WRITE and DONE.
REQ-017 IDLE: when fill_req=1, the block SHALL latch fill_addr and enter REQ on the next edge; fill_busy=0 only in IDLE.
REQ-018 REQ: mem_req=1, with mem_addr equal to the latched address and held stable until mem_ack=1; on mem_ack the block SHALL enter RECV and deassert mem_req on the same edge.
REQ-019 RECV: each cycle with mem_rvalid=1 SHALL store mem_rdata as word k (k=0..31) into bits [16k+15:16k] of a 512-bit block buffer, then increment k.
- Texel t occupies bits [32t+31:32t]: [7:0]=R8, [15:8]=G8, [23:16]=B8, [31:24]=A8.
- After word 31 is stored, the block SHALL enter WRITE.
REQ-020 mem_rvalid SHALL be ignored in IDLE, REQ, WRITE and DONE, including in the mem_ack cycle.
REQ-021 RECV SHALL tolerate any number of idle cycles between words; there is no timeout.
REQ-022 WRITE: for 16 consecutive cycles the block SHALL drive cache_we=1 with cache_widx=0,1,...,15.
- cache_wdata = {R8[7:3], G8[7:2], B8[7:3], A8[7:6]} of texel cache_widx.
- Truncation only, no rounding.
REQ-023 After cache_widx=15, the block SHALL spend one cycle in DONE with fill_done=1 and fill_busy=1, then return to IDLE.
REQ-024 Latency: fill_req accepted at cycle 0 gives mem_req=1 at cycle 1. If the 32nd valid word arrives at cycle r, cache_we is high for cycles r+1..r+16, fill_done at r+17, and the block is in IDLE at r+18.
REQ-025 fill_req while fill_busy=1 SHALL be ignored and not queued.
- A fill_req held high through DONE SHALL be accepted in the first IDLE cycle.
REQ-026 fill_addr changes after acceptance SHALL have no effect on the fill in progress.
REQ-027 mem_burst_len SHALL always be 32, including during reset.
REQ-028 Outside WRITE: cache_we=0, cache_widx=0 and cache_wdata=0.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0 except mem_burst_len=32, and the state SHALL be IDLE with the word and texel counters at 0.
REQ-030 Reset asserted mid-fill in any state SHALL abort the fill immediately: no further cache_we and no fill_done.
REQ-031 Buffer contents need not be cleared by reset.
REQ-032 The first fill_req after reset deassertion SHALL behave as in REQ-017.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Basic fill: fill_addr=0x000100, mem_ack after 3 cycles, 32 back-to-back words where texel t = {A=0xFF, B=0x80, G=0x40, R=t*16}. Required: mem_addr=0x000100; 16 writes in order; texel 0 data {5'd0, 6'd16, 5'd16, 2'd3}; fill_done exactly one cycle, 17 cycles after the last word.
- Gapped data: 1-4 random idle cycles between words, plus rvalid pulses during REQ and WRITE. Required: identical cache output to the gap-free run; stray words ignored.
- Truncation edges: texels 0x00000000, 0xFFFFFFFF and 0x07030307. Required: cache_wdata 0x00000, 0x3FFFF and 0x00000 respectively.
- Busy rejection: fill_req pulsed during RECV with a different fill_addr. Required: no second mem_req until after fill_done; mem_addr unchanged. With fill_req held high, the next mem_req follows 2 cycles after fill_done.
- Mid-fill reset: rst_n low for 1 cycle after word 10, then a new fill. Required: no cache_we from the aborted fill; the new fill completes normally with correct data.
- Arbiter stall: mem_ack withheld for 50 cycles. Required: mem_req and mem_addr stable throughout; fill_busy=1.
